// File: rtl/adc_stream_pkg.sv
// Shared types and constants for the ADC-to-AXI4-Stream packing path.
package adc_stream_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LO    = 2'd1,
    HI    = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int         AXIS_W    = 32;
  localparam logic [3:0] KEEP_FULL = 4'hF;
  localparam logic [3:0] KEEP_HALF = 4'h3;
  localparam int         WCOUNT_W  = 17;
  localparam int         PAYLOAD_W = 1 + 4 + AXIS_W;
endpackage

// File: rtl/adc_word_fifo.sv
// Synchronous word FIFO with a registered output stage; occupancy counts the output register.
module adc_word_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 37
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_wr,
  input  logic [W-1:0] i_wdata,
  input  logic         i_rd,
  output logic         o_full,
  output logic         o_empty,
  output logic         o_vld,
  output logic [W-1:0] o_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_occ;
  logic          r_out_vld;
  logic [W-1:0]  r_out_data;

  logic          w_hs;
  logic          w_wr_acc;
  logic          w_mem_pop;
  logic [CW-1:0] w_mem_cnt;

  assign o_full    = (r_occ == CW'(DEPTH));
  assign o_empty   = (r_occ == '0);
  assign w_hs      = i_rd & r_out_vld;
  // A full FIFO still takes a write when the output word leaves in the same cycle.
  assign w_wr_acc  = i_wr & (~o_full | w_hs);
  assign w_mem_cnt = r_occ - CW'(r_out_vld);
  assign w_mem_pop = (w_mem_cnt != '0) & (~r_out_vld | w_hs);

  always_ff @(posedge i_clk) begin
    if (w_wr_acc) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_occ      <= '0;
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + AW'(1);
      if (w_mem_pop) begin
        r_out_data <= r_mem[r_rptr];
        r_out_vld  <= 1'b1;
        r_rptr     <= r_rptr + AW'(1);
      end else if (w_hs) begin
        r_out_vld <= 1'b0;
      end
      r_occ <= r_occ + CW'(w_wr_acc) - CW'(w_hs);
    end
  end

  assign o_vld  = r_out_vld;
  assign o_data = r_out_data;
endmodule

// File: rtl/adc_axis_packer.sv
// Packs pairs of ADC samples into 32-bit AXI4-Stream words through a small word FIFO.
// Optional ADC_DROP_COUNT_EN adds a saturating dropped-word counter output.
module adc_axis_packer
  import adc_stream_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int SAMPLE_W   = 12
) (
  input  logic                i_CMOS_Clk,
  input  logic                i_Reset,
  input  logic                i_Start,
  input  logic [SAMPLE_W-1:0] i_Sample,
  input  logic                i_Sample_Valid,
  input  logic                i_Sample_Last,
  output logic [AXIS_W-1:0]   m_axis_tdata,
  output logic [3:0]          m_axis_tkeep,
  output logic                m_axis_tlast,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                o_Frame_Done,
  output logic                o_Overflow,
  output logic [WCOUNT_W-1:0] o_Word_Count
`ifdef ADC_DROP_COUNT_EN
  ,
  output logic [15:0]         o_Drop_Count
`endif
);
  function automatic logic [15:0] zext16(input logic [SAMPLE_W-1:0] s);
    return 16'(s);
  endfunction

  function automatic logic [WCOUNT_W-1:0] sat_inc_wc(input logic [WCOUNT_W-1:0] v);
    return (&v) ? v : v + WCOUNT_W'(1);
  endfunction

  state_t                r_state;
  logic [SAMPLE_W-1:0]   r_lo;
  logic                  r_overflow;
  logic                  r_done;
  logic                  r_last_dropped;
  logic [WCOUNT_W-1:0]   r_wcount;

  logic                  w_wr;
  logic [PAYLOAD_W-1:0]  w_word;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_hs;
  logic                  w_drop;
  logic [PAYLOAD_W-1:0]  w_out;

  always_comb begin
    w_wr   = 1'b0;
    w_word = '0;
    case (r_state)
      LO: if (i_Sample_Valid && i_Sample_Last) begin
        w_wr   = 1'b1;
        w_word = {1'b1, KEEP_HALF, 16'h0000, zext16(i_Sample)};
      end
      HI: if (i_Sample_Valid) begin
        w_wr   = 1'b1;
        w_word = {i_Sample_Last, KEEP_FULL, zext16(i_Sample), zext16(r_lo)};
      end
      default: ;
    endcase
  end

  assign w_hs   = m_axis_tvalid & m_axis_tready;
  assign w_drop = w_wr & w_full & ~w_hs;

  adc_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (PAYLOAD_W)
  ) u_fifo (
    .i_clk   (i_CMOS_Clk),
    .i_rst   (i_Reset),
    .i_wr    (w_wr),
    .i_wdata (w_word),
    .i_rd    (m_axis_tready),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_vld   (m_axis_tvalid),
    .o_data  (w_out)
  );

  always_ff @(posedge i_CMOS_Clk) begin
    if (r_state == LO && i_Sample_Valid) r_lo <= i_Sample;
  end

  always_ff @(posedge i_CMOS_Clk) begin
    if (i_Reset) begin
      r_state        <= IDLE;
      r_overflow     <= 1'b0;
      r_done         <= 1'b0;
      r_last_dropped <= 1'b0;
      r_wcount       <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_hs)   r_wcount   <= sat_inc_wc(r_wcount);
      if (w_drop) r_overflow <= 1'b1;
      case (r_state)
        IDLE: if (i_Start) begin
          r_overflow     <= 1'b0;
          r_wcount       <= '0;
          r_last_dropped <= 1'b0;
          r_state        <= LO;
        end
        LO: if (i_Sample_Valid) begin
          if (i_Sample_Last) begin
            r_last_dropped <= w_drop;
            r_state        <= DRAIN;
          end else begin
            r_state <= HI;
          end
        end
        HI: if (i_Sample_Valid) begin
          if (i_Sample_Last) begin
            r_last_dropped <= w_drop;
            r_state        <= DRAIN;
          end else begin
            r_state <= LO;
          end
        end
        DRAIN: begin
          // A frame whose tlast word was dropped can only finish by emptying out.
          if (r_last_dropped) begin
            if (w_empty) r_state <= IDLE;
          end else if (w_hs && m_axis_tlast) begin
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ADC_DROP_COUNT_EN
  logic [15:0] r_drop_cnt;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge i_CMOS_Clk) begin
    if (i_Reset) begin
      r_drop_cnt <= '0;
    end else if (r_state == IDLE && i_Start) begin
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_drop_cnt <= sat_inc16(r_drop_cnt);
    end
  end

  assign o_Drop_Count = r_drop_cnt;
`endif

  assign m_axis_tdata = w_out[AXIS_W-1:0];
  assign m_axis_tkeep = w_out[AXIS_W+3:AXIS_W];
  assign m_axis_tlast = w_out[AXIS_W+4];
  assign o_Frame_Done = r_done;
  assign o_Overflow   = r_overflow;
  assign o_Word_Count = r_wcount;
endmodule

// File: tb/tb_adc_axis_packer.sv
// Scoreboard bench for adc_axis_packer: expected words are queued as samples are driven.
module tb_adc_axis_packer;
  logic        clk = 1'b0;
  logic        i_Reset = 1'b1;
  logic        i_Start = 1'b0;
  logic [11:0] i_Sample = '0;
  logic        i_Sample_Valid = 1'b0;
  logic        i_Sample_Last = 1'b0;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        o_Frame_Done;
  logic        o_Overflow;
  logic [16:0] o_Word_Count;
`ifdef ADC_DROP_COUNT_EN
  logic [15:0] o_Drop_Count;
`endif

  adc_axis_packer #(.FIFO_DEPTH(16), .SAMPLE_W(12)) dut (
    .i_CMOS_Clk     (clk),
    .i_Reset        (i_Reset),
    .i_Start        (i_Start),
    .i_Sample       (i_Sample),
    .i_Sample_Valid (i_Sample_Valid),
    .i_Sample_Last  (i_Sample_Last),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tkeep   (m_axis_tkeep),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .o_Frame_Done   (o_Frame_Done),
    .o_Overflow     (o_Overflow),
    .o_Word_Count   (o_Word_Count)
`ifdef ADC_DROP_COUNT_EN
    ,
    .o_Drop_Count   (o_Drop_Count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [36:0] q[$];
  bit          m_active = 0;
  bit          m_have_lo = 0;
  logic [11:0] m_lo = '0;
  int          cap_left = 1 << 30;
  int          m_drops = 0;

  int          done_cnt = 0;
  int          tlast_cnt = 0;
  bit          exp_done = 0;
  bit          prev_stall = 0;
  logic [36:0] prev_word = '0;
  bit          rand_stop = 0;

  task automatic push_word(input logic [36:0] w);
    if (cap_left > 0) begin
      q.push_back(w);
      cap_left--;
    end else begin
      m_drops++;
    end
  endtask

  task automatic send(input logic [11:0] s, input logic last);
    if (m_active) begin
      if (!m_have_lo) begin
        if (last) begin
          push_word({1'b1, 4'h3, 16'h0000, 4'h0, s});
          m_active = 0;
        end else begin
          m_lo = s;
          m_have_lo = 1;
        end
      end else begin
        push_word({last, 4'hF, 4'h0, s, 4'h0, m_lo});
        m_have_lo = 0;
        if (last) m_active = 0;
      end
    end
    i_Sample = s;
    i_Sample_Last = last;
    i_Sample_Valid = 1'b1;
    @(posedge clk); #1;
    i_Sample_Valid = 1'b0;
    i_Sample_Last = 1'b0;
  endtask

  task automatic pulse_start(input bit arm_model);
    if (arm_model && !m_active) begin
      m_active = 1;
      m_have_lo = 0;
    end
    i_Start = 1'b1;
    @(posedge clk); #1;
    i_Start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_empty(input string tag, input int limit);
    int k;
    for (k = 0; k < limit; k++) begin
      if (q.size() == 0 && !m_axis_tvalid) break;
      @(posedge clk); #1;
    end
    if (k == limit) check_eq({tag, "_timeout"}, 1, 0);
    idle(3);
  endtask

  always @(negedge clk) begin
    logic [36:0] cur;
    logic [36:0] exp_w;
    cur = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
    if (i_Reset) begin
      prev_stall = 0;
      exp_done = 0;
    end else begin
      if (o_Frame_Done) done_cnt++;
      if (exp_done || o_Frame_Done) check_eq("done_pulse", o_Frame_Done, exp_done);
      exp_done = 0;
      if (prev_stall) check_eq("axis_hold", {m_axis_tvalid, cur}, {1'b1, prev_word});
      if (m_axis_tvalid && m_axis_tready) begin
        if (q.size() == 0) begin
          check_eq("extra_word", cur, 37'h0);
        end else begin
          exp_w = q.pop_front();
          check_eq("word", cur, exp_w);
        end
        if (m_axis_tlast) begin
          exp_done = 1;
          tlast_cnt++;
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_word = cur;
    end
  end

  initial begin
    int d0, t0, sent;

    // Reset state
    idle(3);
    check_eq("rst_tvalid", m_axis_tvalid, 0);
    check_eq("rst_tdata", m_axis_tdata, 0);
    check_eq("rst_tkeep", m_axis_tkeep, 0);
    check_eq("rst_tlast", m_axis_tlast, 0);
    check_eq("rst_done", o_Frame_Done, 0);
    check_eq("rst_ovf", o_Overflow, 0);
    check_eq("rst_wcount", o_Word_Count, 0);
`ifdef ADC_DROP_COUNT_EN
    check_eq("rst_dropcnt", o_Drop_Count, 0);
`endif
    i_Reset = 1'b0;
    idle(2);

    // Four samples, explicit expected words, plus latency
    d0 = done_cnt;
    m_axis_tready = 1'b1;
    pulse_start(0);
    q.push_back({1'b0, 4'hF, 32'h0002_0001});
    q.push_back({1'b1, 4'hF, 32'h0004_0003});
    send(12'h001, 0);
    send(12'h002, 0);
    check_eq("latency_c1", m_axis_tvalid, 0);
    @(posedge clk); #1;
    check_eq("latency_c2", m_axis_tvalid, 1);
    send(12'h003, 0);
    send(12'h004, 1);
    wait_empty("t1", 50);
    check_eq("t1_wcount", o_Word_Count, 2);
    check_eq("t1_done", done_cnt - d0, 1);

    // Odd-length frame ends in a half word
    d0 = done_cnt;
    pulse_start(0);
    q.push_back({1'b0, 4'hF, 32'h0123_0ABC});
    q.push_back({1'b1, 4'h3, 32'h0000_0FFF});
    send(12'hABC, 0);
    send(12'h123, 0);
    send(12'hFFF, 1);
    wait_empty("t2", 50);
    check_eq("t2_wcount", o_Word_Count, 2);
    check_eq("t2_done", done_cnt - d0, 1);
    check_eq("t2_ovf", o_Overflow, 0);

    // Overflow with tready held low for 40 pairs
    d0 = done_cnt;
    m_axis_tready = 1'b0;
    cap_left = 16;
    m_drops = 0;
    pulse_start(1);
    for (int i = 0; i < 80; i++) send(12'((i * 37 + 5) & 12'hFFF), i == 79);
    idle(2);
    check_eq("ovf_flag", o_Overflow, 1);
    check_eq("ovf_tvalid", m_axis_tvalid, 1);
    check_eq("ovf_model_drops", m_drops, 24);
`ifdef ADC_DROP_COUNT_EN
    check_eq("ovf_dropcnt", o_Drop_Count, 24);
`endif
    m_axis_tready = 1'b1;
    cap_left = 1 << 30;
    wait_empty("ovf", 200);
    check_eq("ovf_wcount", o_Word_Count, 16);
    check_eq("ovf_no_done", done_cnt - d0, 0);
    check_eq("ovf_sticky", o_Overflow, 1);

    // Start during HI is ignored; accepted start clears status
    d0 = done_cnt;
    pulse_start(1);
    check_eq("start_clr_ovf", o_Overflow, 0);
    check_eq("start_clr_wcount", o_Word_Count, 0);
`ifdef ADC_DROP_COUNT_EN
    check_eq("start_clr_dropcnt", o_Drop_Count, 0);
`endif
    send(12'h111, 0);
    pulse_start(1);
    send(12'h222, 0);
    send(12'h333, 0);
    send(12'h444, 1);
    wait_empty("t5", 50);
    check_eq("t5_wcount", o_Word_Count, 2);
    check_eq("t5_done", done_cnt - d0, 1);

    // Long frame with random tready and sparse samples
    d0 = done_cnt;
    t0 = tlast_cnt;
    pulse_start(1);
    rand_stop = 0;
    fork
      begin
        sent = 0;
        while (sent < 2000) begin
          if ($urandom_range(0, 2) == 0) begin
            send(12'($urandom_range(0, 4095)), sent == 1999);
            sent++;
          end else begin
            idle(1);
          end
        end
        rand_stop = 1;
      end
      begin
        while (!rand_stop) begin
          m_axis_tready = ($urandom_range(0, 2) != 0);
          @(posedge clk); #1;
        end
      end
    join
    m_axis_tready = 1'b1;
    wait_empty("rand", 500);
    check_eq("rand_wcount", o_Word_Count, 1000);
    check_eq("rand_tlast", tlast_cnt - t0, 1);
    check_eq("rand_done", done_cnt - d0, 1);
    check_eq("rand_ovf", o_Overflow, 0);

    // Reset mid-frame with the FIFO half full
    m_axis_tready = 1'b0;
    pulse_start(1);
    for (int i = 0; i < 16; i++) send(12'(i + 100), 0);
    idle(2);
    check_eq("mid_tvalid_pre", m_axis_tvalid, 1);
    i_Reset = 1'b1;
    @(posedge clk); #1;
    check_eq("mid_rst_tvalid", m_axis_tvalid, 0);
    check_eq("mid_rst_wcount", o_Word_Count, 0);
    i_Reset = 1'b0;
    q.delete();
    m_active = 0;
    m_have_lo = 0;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 4; i++) send(12'(i + 7), i == 3);
    idle(4);
    check_eq("idle_ignore_tvalid", m_axis_tvalid, 0);
    check_eq("idle_ignore_wcount", o_Word_Count, 0);
    d0 = done_cnt;
    pulse_start(1);
    send(12'h005, 0);
    send(12'h006, 1);
    wait_empty("post_rst", 50);
    check_eq("post_rst_wcount", o_Word_Count, 1);
    check_eq("post_rst_done", done_cnt - d0, 1);
    check_eq("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
